instruction_fetch: RTL
======================

# instruction_fetch

Fetch stage of the single-issue RISC-V datapath: owns the program counter, issues one instruction-memory read at a time over a request/ready handshake, and presents the fetched 32-bit word with its PC to the decode stage (immediate generator, register file, control) over a valid/ready handshake. Taken branches from the execute stage redirect the PC. The branch target is formed here from the branch PC and the sign-extended branch immediate. At most one instruction is in flight or held at any time.

## Interface
- RESET_PC, 32'h0000_0000, PC loaded on reset; must be 4-byte aligned.
- clock  input  1  single clock; all state updates on posedge.
- reset  input  1  asynchronous, active-low reset.
- memRequest  output  1  read request to instruction memory.
- memAddress  output  32  word-aligned read address; bits [1:0] always 0.
- memReady  input  1  memory completes the read in this cycle; memData valid in the same cycle.
- memData  input  32  instruction word returned by memory.
- instruction  output  32  fetched instruction to decode.
- instructionPc  output  32  address the instruction was fetched from.
- instructionValid  output  1  instruction/instructionPc hold a valid entry.
- instructionReady  input  1  decode accepts the entry this cycle.
- branchTaken  input  1  one-cycle redirect pulse from execute.
- branchBase  input  32  PC of the branch instruction.
- branchOffset  input  32  sign-extended branch immediate, in half-words.

## Operation
- All outputs are registered. States: IDLE, FETCH, HOLD. A `discard` flag and a 32-bit `pc` register are also held.
- Target = branchBase + {branchOffset[30:0], 1'b0}, computed modulo 2^32 with bits [1:0] forced to 0.
- **IDLE** (entered only from reset):
  - Next cycle: memRequest=1, memAddress=pc, state goes to FETCH.
  - branchTaken in IDLE loads pc=target first.
- **FETCH**:
  - memRequest and memAddress stay stable until memReady=1. Requests are never withdrawn.
  - On memReady with discard=0: latch instruction=memData and instructionPc=memAddress, set instructionValid=1, drop memRequest, go to HOLD.
  - On memReady with discard=1: drop the data, clear discard, request memAddress=pc next cycle, stay in FETCH.
  - branchTaken while memRequest=1 and memReady=0: set discard=1 and pc=target.
  - branchTaken in the same cycle as memReady: drop the data, pc=target, issue a new request next cycle. Discard is not set.
- **HOLD**:
  - On instructionValid & instructionReady: pc=pc+4 (wraps modulo 2^32), instructionValid=0, memRequest=1 with the new pc, go to FETCH.
  - On branchTaken (regardless of instructionReady, redirect wins): instructionValid=0, pc=target, issue a request to target, go to FETCH.
- instruction and instructionPc hold their value when instructionValid=0. Downstream must ignore them.

## Timing
- **Reset** (reset=0): state=IDLE, pc=RESET_PC, memRequest=0, memAddress=0, instruction=0, instructionPc=0, instructionValid=0, discard=0.
- **Reset mid-transaction:** any in-flight read is abandoned. Memory must tolerate memRequest dropping asynchronously.
- **After reset release:** first posedge → memRequest=1, memAddress=RESET_PC.
- **Fetch latency:** memReady sampled high at edge N → instructionValid=1 after edge N.
- **Next fetch:** accept at edge M → memRequest=1 with address pc+4 after edge M.
- **Throughput:** ≥2 cycles per instruction (zero-wait memory gives one instruction every 2 cycles).
- **Redirect during HOLD:** branchTaken at edge B → memAddress=target after edge B; the held instruction is never accepted.
- **Redirect during a pending request:** the stale response is absorbed. The first memory response that can raise instructionValid is the one for target.

## Test plan
- **Reset and sequential fetch:** RESET_PC=0x100, zero-wait memory, instructionReady=1 → memAddress sequence 0x100, 0x104, 0x108; instructionPc matches; instructionValid high every other cycle.
- **Memory wait states:** memReady delayed 3 cycles → memRequest and memAddress stable for all 3 cycles; a single instructionValid pulse carries the correct data.
- **Decode backpressure:** instructionReady=0 for 5 cycles → instructionValid, instruction and instructionPc held; no new memRequest issued until accept.
- **Branch in HOLD:** branchBase=0x200, branchOffset=0xFFFF_FFF8 (−8 half-words) → next memAddress=0x1F0; the held word is dropped.
- **Branch with pending request:** branchTaken while waiting, memReady two cycles later with 0xDEADBEEF → 0xDEADBEEF never presented; next request address = target.
- **Wrap and async reset:** pc=0xFFFF_FFFC accepted → next memAddress=0x0000_0000. Asserting reset mid-FETCH → all outputs at reset values immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/instruction_fetch_if.sv
// Bus bundle around the fetch stage: the instruction-memory read port, the
// fetch-to-decode handoff and the redirect inputs coming back from execute.
interface instruction_fetch_if;
    logic        memRequest;
    logic [31:0] memAddress;
    logic        memReady;
    logic [31:0] memData;

    logic [31:0] instruction;
    logic [31:0] instructionPc;
    logic        instructionValid;
    logic        instructionReady;

    logic        branchTaken;
    logic [31:0] branchBase;
    logic [31:0] branchOffset;

    modport master (
        output memRequest, memAddress, instruction, instructionPc, instructionValid,
        input  memReady, memData, instructionReady, branchTaken, branchBase, branchOffset
    );

    modport slave (
        input  memRequest, memAddress, instruction, instructionPc, instructionValid,
        output memReady, memData, instructionReady, branchTaken, branchBase, branchOffset
    );
endinterface

// File: rtl/instruction_fetch.sv
// Fetch stage: owns the PC and keeps at most one instruction in flight or held
// for decode. Branch redirects from execute override the sequential PC.
module instruction_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input logic                  clock,
    input logic                  reset,
    instruction_fetch_if.master  bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2
    } fetchState_t;

    fetchState_t state, stateNext;

    logic [31:0] pc, pcNext;
    logic        discard, discardNext;
    logic        memRequestReg, memRequestNext;
    logic [31:0] memAddressReg, memAddressNext;
    logic [31:0] instructionReg, instructionNext;
    logic [31:0] instructionPcReg, instructionPcNext;
    logic        instructionValidReg, instructionValidNext;
    logic [31:0] target;

    // Offset counts half-words; the shift drops bit 31, which is the wrap we want.
    assign target = (bus.branchBase + (bus.branchOffset << 1)) & 32'hFFFF_FFFC;

    assign bus.memRequest       = memRequestReg;
    assign bus.memAddress       = memAddressReg;
    assign bus.instruction      = instructionReg;
    assign bus.instructionPc    = instructionPcReg;
    assign bus.instructionValid = instructionValidReg;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state               <= IDLE;
            pc                  <= RESET_PC;
            discard             <= 1'b0;
            memRequestReg       <= 1'b0;
            memAddressReg       <= 32'h0000_0000;
            instructionReg      <= 32'h0000_0000;
            instructionPcReg    <= 32'h0000_0000;
            instructionValidReg <= 1'b0;
        end else begin
            state               <= stateNext;
            pc                  <= pcNext;
            discard             <= discardNext;
            memRequestReg       <= memRequestNext;
            memAddressReg       <= memAddressNext;
            instructionReg      <= instructionNext;
            instructionPcReg    <= instructionPcNext;
            instructionValidReg <= instructionValidNext;
        end
    end

    always_comb begin
        stateNext            = state;
        pcNext               = pc;
        discardNext          = discard;
        memRequestNext       = memRequestReg;
        memAddressNext       = memAddressReg;
        instructionNext      = instructionReg;
        instructionPcNext    = instructionPcReg;
        instructionValidNext = instructionValidReg;

        unique case (state)
            IDLE: begin
                if (bus.branchTaken) begin
                    pcNext         = target;
                    memAddressNext = target;
                end else begin
                    memAddressNext = pc;
                end
                memRequestNext = 1'b1;
                stateNext      = FETCH;
            end

            FETCH: begin
                // A redirect racing the response restarts cleanly, so no discard is needed.
                if (bus.branchTaken && bus.memReady) begin
                    pcNext         = target;
                    memAddressNext = target;
                    discardNext    = 1'b0;
                end else if (bus.branchTaken) begin
                    pcNext      = target;
                    discardNext = 1'b1;
                end else if (bus.memReady && discard) begin
                    discardNext    = 1'b0;
                    memAddressNext = pc;
                end else if (bus.memReady) begin
                    instructionNext      = bus.memData;
                    instructionPcNext    = memAddressReg;
                    instructionValidNext = 1'b1;
                    memRequestNext       = 1'b0;
                    stateNext            = HOLD;
                end
            end

            HOLD: begin
                if (bus.branchTaken) begin
                    instructionValidNext = 1'b0;
                    pcNext               = target;
                    memRequestNext       = 1'b1;
                    memAddressNext       = target;
                    stateNext            = FETCH;
                end else if (bus.instructionReady) begin
                    instructionValidNext = 1'b0;
                    pcNext               = pc + 32'd4;
                    memRequestNext       = 1'b1;
                    memAddressNext       = pc + 32'd4;
                    stateNext            = FETCH;
                end
            end

            default: begin
                stateNext = IDLE;
            end
        endcase
    end

endmodule
